// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronizes and debounces two buttons, runs the
// IDLE/RUN/PAUSE/LAP/CLEAR state machine and generates the count-enable pulse.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV     = 100,
   parameter int unsigned DEBOUNCE_LEN = 4
) (
   input  logic       clk_out,
   input  logic       reset_n,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic [2:0] state,
   output logic       increase,
   output logic       lap_freeze
);

   typedef enum logic [2:0] {
      StIdle  = 3'b000,
      StRun   = 3'b001,
      StPause = 3'b010,
      StLap   = 3'b011,
      StClear = 3'b100
   } state_e;

   localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);
   localparam logic [7:0]  DebLast  = 8'(DEBOUNCE_LEN - 1);

   // Bit 0 is the start button, bit 1 the lap button.
   logic [1:0] btn_raw;
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] deb_q, deb_d;
   logic [1:0] deb_prev_q;
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];
   logic [1:0] press;

   state_e      state_q, state_d;
   logic [15:0] prescaler_q, prescaler_d;
   logic        counting;

   assign btn_raw = {btn_lap, btn_start};

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 8'd0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DebLast) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   assign press = deb_q & ~deb_prev_q;

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 2'b00;
         sync2_q    <= 2'b00;
         deb_q      <= 2'b00;
         deb_prev_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 2; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Start is checked first everywhere, so a coincident lap press is dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (press[0]) state_d = StRun;
         end
         StRun: begin
            if (press[0])      state_d = StPause;
            else if (press[1]) state_d = StLap;
         end
         StPause: begin
            if (press[0])      state_d = StRun;
            else if (press[1]) state_d = StClear;
         end
         StLap: begin
            if (press[0])      state_d = StPause;
            else if (press[1]) state_d = StRun;
         end
         StClear: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign counting = (state_q == StRun) || (state_q == StLap);

   always_comb begin
      prescaler_d = 16'd0;
      if (counting) begin
         prescaler_d = (prescaler_q == TickLast) ? 16'd0 : prescaler_q + 16'd1;
      end else if (state_q == StPause) begin
         prescaler_d = prescaler_q;
      end
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         prescaler_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         prescaler_q <= prescaler_d;
      end
   end

   assign state      = state_q;
   assign increase   = counting && (prescaler_q == TickLast);
   assign lap_freeze = (state_q == StLap);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_LEN=3.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_stopwatch_ctrl;

   logic       clk_out;
   logic       reset_n;
   logic       btn_start;
   logic       btn_lap;
   logic [2:0] state;
   logic       increase;
   logic       lap_freeze;

   stopwatch_ctrl #(
      .TICK_DIV    (4),
      .DEBOUNCE_LEN(3)
   ) dut (
      .clk_out   (clk_out),
      .reset_n   (reset_n),
      .btn_start (btn_start),
      .btn_lap   (btn_lap),
      .state     (state),
      .increase  (increase),
      .lap_freeze(lap_freeze)
   );

   initial clk_out = 1'b0;
   always #5 clk_out = ~clk_out;

   typedef struct {
      logic       start;
      logic       lap;
      logic [2:0] st;
      logic       inc;
      logic       lf;
   } vec_t;

   vec_t vec [50];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   t        = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, got, exp, t);
   endtask

   task automatic do_reset(input logic hold_start);
      @(negedge clk_out);
      reset_n   = 1'b0;
      btn_start = hold_start;
      btn_lap   = 1'b0;
      repeat (2) @(negedge clk_out);
      check("reset_outputs", {state, increase, lap_freeze}, 5'b0);
      reset_n = 1'b1;
   endtask

   task automatic wait_to(input int target);
      while (t < target) begin
         @(negedge clk_out);
         t++;
      end
   endtask

   // Press start from IDLE; t=0 is the first cycle visible in RUN.
   task automatic enter_run();
      do_reset(1'b0);
      btn_start = 1'b1;
      repeat (6) @(negedge clk_out);
      check("enter_run", state, 3'b001);
      btn_start = 1'b0;
      t = 0;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         btn_start = vec[i].start;
         btn_lap   = vec[i].lap;
         @(negedge clk_out);
         check($sformatf("vec%0d", i), {state, increase, lap_freeze},
               {vec[i].st, vec[i].inc, vec[i].lf});
      end
   endtask

   initial begin
      logic bad;
      reset_n   = 1'b0;
      btn_start = 1'b0;
      btn_lap   = 1'b0;

      // 0..19: start held 10 cycles from reset; 20..49: both buttons bouncing.
      for (int i = 0; i < 20; i++) begin
         vec[i].start = (i < 10);
         vec[i].lap   = 1'b0;
         vec[i].st    = (i >= 5) ? 3'b001 : 3'b000;
         vec[i].inc   = (i == 8) || (i == 12) || (i == 16);
         vec[i].lf    = 1'b0;
      end
      for (int i = 20; i < 50; i++) begin
         vec[i].start = (i < 40) && (i % 2 == 0);
         vec[i].lap   = (i < 40) && (i % 2 == 1);
         vec[i].st    = 3'b000;
         vec[i].inc   = 1'b0;
         vec[i].lf    = 1'b0;
      end

      do_reset(1'b0);
      run_vectors(0, 19);
      do_reset(1'b0);
      run_vectors(20, 49);

      // Pause at prescaler 2, hold 50 cycles, resume.
      enter_run();
      wait_to(3);  check("run_inc_first", increase, 1);
      wait_to(12); btn_start = 1'b1;
      wait_to(17); check("pre_pause_state", state, 3'b001);
      wait_to(18); check("pause_state", {state, increase}, {3'b010, 1'b0});
      btn_start = 1'b0;
      bad = 1'b0;
      while (t < 68) begin
         wait_to(t + 1);
         if (state !== 3'b010 || increase !== 1'b0) bad = 1'b1;
      end
      check("pause_hold", bad, 0);
      btn_start = 1'b1;
      wait_to(73); check("still_paused", state, 3'b010);
      wait_to(74); check("resume_state", {state, increase}, {3'b001, 1'b0});
      btn_start = 1'b0;
      wait_to(75); check("resume_inc", increase, 1);
      wait_to(76); check("resume_inc_low", increase, 0);
      wait_to(79); check("resume_inc_next", increase, 1);

      // Lap and back to run; prescaler keeps running throughout.
      enter_run();
      wait_to(8);  btn_lap = 1'b1;
      wait_to(14); check("lap_enter", {state, lap_freeze}, {3'b011, 1'b1});
      btn_lap = 1'b0;
      wait_to(15); check("lap_inc0", increase, 1);
      wait_to(16); check("lap_inc_low", increase, 0);
      wait_to(19); check("lap_inc1", increase, 1);
      wait_to(22); btn_lap = 1'b1;
      wait_to(23); check("lap_inc2", increase, 1);
      wait_to(27); check("lap_last", {state, increase}, {3'b011, 1'b1});
      wait_to(28); check("lap_exit", {state, lap_freeze}, {3'b001, 1'b0});
      btn_lap = 1'b0;
      wait_to(31); check("lap_exit_inc", increase, 1);

      // Clear from pause; a start press landing in the CLEAR cycle is dropped.
      enter_run();
      wait_to(12); btn_start = 1'b1;
      wait_to(18); check("clr_pause", state, 3'b010);
      btn_start = 1'b0;
      wait_to(26); btn_lap = 1'b1;
      wait_to(27); btn_start = 1'b1;
      wait_to(31); check("clr_pre", state, 3'b010);
      wait_to(32); check("clr_state", state, 3'b100);
      btn_lap = 1'b0;
      wait_to(33); check("clr_idle", state, 3'b000);
      check("clr_prescaler", dut.prescaler_q, 0);
      btn_start = 1'b0;
      wait_to(34); check("clr_start_ignored", {state, increase}, {3'b000, 1'b0});
      wait_to(40); check("clr_idle_hold", state, 3'b000);
      btn_start = 1'b1;
      wait_to(46); check("clr_restart", state, 3'b001);
      btn_start = 1'b0;
      wait_to(48); check("clr_restart_noinc", increase, 0);
      wait_to(49); check("clr_restart_inc", increase, 1);

      // Simultaneous presses, then asynchronous reset mid-cycle in LAP.
      enter_run();
      wait_to(12); btn_start = 1'b1; btn_lap = 1'b1;
      wait_to(18); check("simul_start_wins", {state, lap_freeze}, {3'b010, 1'b0});
      btn_start = 1'b0; btn_lap = 1'b0;
      wait_to(19); check("simul_lap_dropped", state, 3'b010);
      wait_to(26); btn_start = 1'b1;
      wait_to(32); check("simul_resume", state, 3'b001);
      btn_start = 1'b0;
      wait_to(33); check("simul_inc", increase, 1);
      wait_to(40); btn_lap = 1'b1;
      wait_to(46); check("simul_lap", state, 3'b011);
      btn_lap = 1'b0;
      wait_to(49); check("pre_reset", {state, increase, lap_freeze}, {3'b011, 1'b1, 1'b1});
      #2;
      reset_n   = 1'b0;
      btn_start = 1'b1;
      #1;
      check("async_reset", {state, increase, lap_freeze}, 5'b0);
      @(negedge clk_out);
      @(negedge clk_out);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_out);
      check("held_pre", state, 3'b000);
      @(negedge clk_out);
      check("held_press", state, 3'b001);
      btn_start = 1'b0;
      repeat (2) @(negedge clk_out);
      check("post_reset_noinc", increase, 0);
      @(negedge clk_out);
      check("post_reset_inc", increase, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
